// File: rtl/pmem_arbiter.sv
// pmem_arbiter
// Shares the single physical-memory port between the I-cache line-fill path
// and the D-cache line-fill/writeback path. A request is captured when it is
// granted and held on pmem_* until pmem_resp. The completion pulse and the
// read line are steered back only to the cache that owns the transfer.
//
// Build option: define PMEM_ARB_ROUND_ROBIN_EN to alternate grants when both
// caches are waiting in IDLE. Without it the D-cache always wins a tie.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   icache_read/addr                 I-cache fill request (held until resp)
//   icache_resp/rdata                I-cache completion pulse and fill line
//   dcache_read/write/addr/wdata     D-cache fill or writeback request
//   dcache_resp/rdata                D-cache completion pulse and fill line
//   pmem_read/write/address/wdata    registered request to physical memory
//   pmem_resp/rdata                  physical memory completion and read line
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_resp,
  output logic [LINE_W-1:0] icache_rdata,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_resp,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]        state_reg;
  logic              read_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;

  logic i_pending;
  logic d_pending;
  logic grant_d;

  assign i_pending = icache_read;
  assign d_pending = dcache_read | dcache_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // 0 = I-cache was served last, 1 = D-cache was served last.
  logic last_grant_d_reg;

  // On a tie the cache that was not served last goes first.
  assign grant_d = d_pending & (~i_pending | ~last_grant_d_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_d_reg <= 1'b0;
    end else if (state_reg != IDLE && pmem_resp) begin
      last_grant_d_reg <= (state_reg == SERVE_D);
    end
  end
`else
  assign grant_d = d_pending;
`endif

  // The pmem side is driven purely from captured registers so the caches
  // may change their inputs mid-transfer without disturbing memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg <= SERVE_D;
            addr_reg  <= dcache_addr;
            wdata_reg <= dcache_wdata;
            // Write wins if both D strobes are (illegally) high.
            write_reg <= dcache_write;
            read_reg  <= ~dcache_write;
          end else if (i_pending) begin
            state_reg <= SERVE_I;
            addr_reg  <= icache_addr;
            write_reg <= 1'b0;
            read_reg  <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          // Returning to IDLE forces one idle cycle between transfers so a
          // requester can drop its request after seeing resp.
          if (pmem_resp) begin
            state_reg <= IDLE;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          read_reg  <= 1'b0;
          write_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = read_reg;
  assign pmem_write   = write_reg;
  assign pmem_address = addr_reg;
  assign pmem_wdata   = wdata_reg;

  // pmem_resp seen in IDLE matches neither serve state and is dropped.
  assign icache_resp  = (state_reg == SERVE_I) & pmem_resp;
  assign dcache_resp  = (state_reg == SERVE_D) & pmem_resp;
  assign icache_rdata = icache_resp ? pmem_rdata : '0;
  assign dcache_rdata = dcache_resp ? pmem_rdata : '0;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && dcache_read && dcache_write) begin
      $error("pmem_arbiter: dcache_read and dcache_write both high");
    end
  end
`endif

endmodule
